// File: rtl/stdcore_bfifo_scanrd.sv
// Block-FIFO consumer: waits for a full BW x BH block, scans it in raster or transposed
// order through a 2-entry skid buffer onto a valid/ready stream, then releases the block.
module stdcore_bfifo_scanrd #(
  parameter int DW = 8,
  parameter int AW = 6,
  parameter int BW = 8,
  parameter int BH = 8
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          rst_n,
  input  logic          en,
  input  logic          tr,
  input  logic [DW-1:0] c,
  output logic [AW-1:0] c_raddr,
  output logic          c_re_n,
  output logic [AW:0]   c_pblk,
  input  logic [AW:0]   c_st,
  output logic [DW-1:0] o_data,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic          o_sob,
  output logic          o_eob,
  output logic          busy
);

  localparam int XW = (BW > 1) ? $clog2(BW) : 1;
  localparam int YW = (BH > 1) ? $clog2(BH) : 1;
  localparam logic [AW:0]   BLK = (AW+1)'(BW * BH);
  localparam logic [AW-1:0] BWA = AW'(BW);
  localparam logic [XW-1:0] XMAX = XW'(BW - 1);
  localparam logic [YW-1:0] YMAX = YW'(BH - 1);

  typedef enum logic [1:0] {IDLE, READ, REL, GAP} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          tr_q;
  logic          start, start_blk, issue, last, last_x, last_y, push, pop;
  logic          inflight, inf_sob, inf_eob;
  logic [1:0]    cnt;
  logic          wptr, rptr;
  logic [DW-1:0] sk_data [2];
  logic          sk_sob  [2];
  logic          sk_eob  [2];

  assign start     = en && (c_st >= BLK);
  // GAP also acts as an idle slot so back-to-back blocks run every BW*BH+2 cycles
  assign start_blk = ((state == IDLE) || (state == GAP)) && start;
  assign last_x    = (x == XMAX);
  assign last_y    = (y == YMAX);
  assign pop       = o_vld && o_rdy;
  assign push      = inflight;
  assign issue     = (state == READ) &&
                     (({1'b0, cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign last      = issue && last_x && last_y;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (last) state_nxt = REL;
      REL:     state_nxt = GAP;
      GAP:     state_nxt = start ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      tr_q  <= 1'b0;
    end else if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      tr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_blk) tr_q <= tr;
      if (issue) begin
        if (!tr_q) begin
          if (last_x) begin
            x <= '0;
            y <= last_y ? '0 : y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end else begin
          if (last_y) begin
            y <= '0;
            x <= last_x ? '0 : x + 1'b1;
          end else begin
            y <= y + 1'b1;
          end
        end
      end
    end
  end

  // RAM read latency stage plus the skid buffer that absorbs it under backpressure
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      inflight <= 1'b0;
      inf_sob  <= 1'b0;
      inf_eob  <= 1'b0;
      cnt      <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        sk_data[i] <= '0;
        sk_sob[i]  <= 1'b0;
        sk_eob[i]  <= 1'b0;
      end
    end else if (!rst_n) begin
      inflight <= 1'b0;
      inf_sob  <= 1'b0;
      inf_eob  <= 1'b0;
      cnt      <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        sk_data[i] <= '0;
        sk_sob[i]  <= 1'b0;
        sk_eob[i]  <= 1'b0;
      end
    end else begin
      inflight <= issue;
      inf_sob  <= issue && (x == '0) && (y == '0);
      inf_eob  <= last;
      if (push) begin
        sk_data[wptr] <= c;
        sk_sob[wptr]  <= inf_sob;
        sk_eob[wptr]  <= inf_eob;
        wptr          <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      if (push && !pop) cnt <= cnt + 2'd1;
      else if (!push && pop) cnt <= cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (arst_n && rst_n) begin
      assert (!(push && !pop && (cnt == 2'd2))) else $error("skid buffer overflow");
      assert (!(start_blk && (c_st < BLK))) else $error("block start with insufficient stock");
    end
  end

  assign o_vld   = (cnt != 2'd0);
  assign o_data  = o_vld ? sk_data[rptr] : '0;
  assign o_sob   = o_vld && sk_sob[rptr];
  assign o_eob   = o_vld && sk_eob[rptr];
  assign c_re_n  = !issue;
  assign c_raddr = AW'(y) * BWA + AW'(x);
  assign c_pblk  = (state == REL) ? BLK : '0;
  assign busy    = (state != IDLE) || o_vld;

endmodule

// File: tb/tb_stdcore_bfifo_scanrd.sv
// Directed bench for stdcore_bfifo_scanrd: behavioural block FIFO model, output monitor,
// and hand-computed expected scan sequences for raster, transposed, stall, stock and reset cases.
module tb_stdcore_bfifo_scanrd;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int BW = 4;
  localparam int BH = 4;
  localparam int DEPTH = 64;

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
    int            c;
  } samp_t;

  logic          clk = 1'b0;
  logic          arst_n, rst_n, en, tr, o_rdy;
  logic [DW-1:0] c;
  logic [AW-1:0] c_raddr;
  logic          c_re_n;
  logic [AW:0]   c_pblk, c_st;
  logic [DW-1:0] o_data;
  logic          o_vld, o_sob, o_eob, busy;

  logic [DW-1:0] mem [DEPTH];
  int loaded = 0;
  int released = 0;
  int relBase = 0;
  int cyc = 0;
  int rdyMode = 0;
  int checks = 0;
  int failures = 0;

  samp_t smp[$];
  int    pblkCycs[$];
  int    pblkVals[$];
  int    startCycs[$];
  int    readCount = 0;
  int    lastReadCyc = 0;
  logic  stallPrev = 1'b0;
  logic [DW-1:0] stallData = '0;
  int    trExp[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  stdcore_bfifo_scanrd #(.DW(DW), .AW(AW), .BW(BW), .BH(BH)) dut (
    .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .en(en), .tr(tr), .c(c),
    .c_raddr(c_raddr), .c_re_n(c_re_n), .c_pblk(c_pblk), .c_st(c_st),
    .o_data(o_data), .o_vld(o_vld), .o_rdy(o_rdy), .o_sob(o_sob), .o_eob(o_eob),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign c_st = (AW+1)'(loaded - released);

  // FIFO model: registered read relative to the current block base, release advances base
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!c_re_n) c <= mem[(relBase + int'(c_raddr)) % DEPTH];
    if (c_pblk != '0) begin
      released <= released + int'(c_pblk);
      relBase  <= (relBase + int'(c_pblk)) % DEPTH;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdyMode)
      0:       o_rdy = 1'b0;
      1:       o_rdy = 1'b1;
      default: o_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Monitor: records accepted samples, reads, releases and checks hold-under-stall
  always @(negedge clk) begin
    if (arst_n && rst_n) begin
      if (stallPrev) begin
        checkOutput("stall_vld", 32'(o_vld), 32'd1);
        checkOutput("stall_data", 32'(o_data), 32'(stallData));
      end
      stallPrev = o_vld && !o_rdy;
      stallData = o_data;
      if (o_vld && o_rdy) smp.push_back('{o_data, o_sob, o_eob, cyc});
      if (!c_re_n) begin
        readCount++;
        lastReadCyc = cyc;
        if (c_raddr == '0) startCycs.push_back(cyc);
      end
      if (c_pblk != '0) begin
        pblkCycs.push_back(cyc);
        pblkVals.push_back(int'(c_pblk));
      end
    end else begin
      stallPrev = 1'b0;
    end
  end

  task automatic clearMon();
    smp.delete();
    pblkCycs.delete();
    pblkVals.delete();
    startCycs.delete();
    readCount = 0;
  endtask

  task automatic fillBlocks(input int nblk);
    for (int k = 0; k < nblk; k++)
      for (int i = 0; i < BW * BH; i++)
        mem[(relBase + 16 * k + i) % DEPTH] = DW'(16 * k + i);
  endtask

  task automatic applyStimulus(input logic enV, input logic trV, input int addStock);
    @(posedge clk);
    #1;
    en = enV;
    tr = trV;
    loaded += addStock;
  endtask

  task automatic waitSamples(input int n, input int budget);
    int k = 0;
    while (smp.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    @(negedge clk);
    #1;
    while (busy && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_re_n"}, 32'(c_re_n), 32'd1);
    checkOutput({tag, "_raddr"}, 32'(c_raddr), 32'd0);
    checkOutput({tag, "_pblk"}, 32'(c_pblk), 32'd0);
    checkOutput({tag, "_vld"}, 32'(o_vld), 32'd0);
    checkOutput({tag, "_sob"}, 32'(o_sob), 32'd0);
    checkOutput({tag, "_eob"}, 32'(o_eob), 32'd0);
    checkOutput({tag, "_data"}, 32'(o_data), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic checkBlock(input string tag, input logic useTr);
    checkOutput({tag, "_count"}, 32'(smp.size()), 32'd16);
    for (int i = 0; i < 16 && i < smp.size(); i++) begin
      checkOutput({tag, "_data"}, 32'(smp[i].d), useTr ? 32'(trExp[i]) : 32'(i));
      checkOutput({tag, "_sob"}, 32'(smp[i].s), 32'(i == 0));
      checkOutput({tag, "_eob"}, 32'(smp[i].e), 32'(i == 15));
    end
  endtask

  initial begin
    arst_n = 1'b0;
    rst_n  = 1'b1;
    en     = 1'b0;
    tr     = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    arst_n = 1'b1;

    // Raster scan at full rate
    clearMon();
    fillBlocks(1);
    rdyMode = 1;
    applyStimulus(1'b1, 1'b0, 16);
    waitSamples(16, 100);
    waitIdle(50);
    checkBlock("raster", 1'b0);
    for (int i = 1; i < smp.size(); i++)
      checkOutput("raster_consecutive", 32'(smp[i].c - smp[0].c), 32'(i));
    checkOutput("raster_pblk_n", 32'(pblkCycs.size()), 32'd1);
    if (pblkCycs.size() > 0) begin
      checkOutput("raster_pblk_val", 32'(pblkVals[0]), 32'd16);
      checkOutput("raster_pblk_lat", 32'(pblkCycs[0] - lastReadCyc), 32'd1);
    end

    // Transposed scan
    clearMon();
    fillBlocks(1);
    applyStimulus(1'b1, 1'b1, 16);
    waitSamples(16, 100);
    waitIdle(50);
    checkBlock("transp", 1'b1);

    // Random backpressure
    clearMon();
    fillBlocks(1);
    rdyMode = 2;
    applyStimulus(1'b1, 1'b0, 16);
    waitSamples(16, 400);
    waitIdle(100);
    checkBlock("bp", 1'b0);
    rdyMode = 1;

    // Insufficient stock holds IDLE until a full block is present
    clearMon();
    fillBlocks(1);
    applyStimulus(1'b1, 1'b0, 15);
    repeat (20) @(negedge clk);
    checkOutput("stock_reads", 32'(readCount), 32'd0);
    checkOutput("stock_vld", 32'(o_vld), 32'd0);
    applyStimulus(1'b1, 1'b0, 1);
    @(negedge clk);
    checkOutput("stock_same_cycle", 32'(c_re_n), 32'd1);
    @(negedge clk);
    checkOutput("stock_first_read", 32'(c_re_n), 32'd0);
    waitSamples(16, 100);
    waitIdle(50);
    checkBlock("stock", 1'b0);

    // Three blocks back to back
    clearMon();
    fillBlocks(3);
    applyStimulus(1'b1, 1'b0, 48);
    waitSamples(48, 300);
    waitIdle(50);
    checkOutput("b2b_count", 32'(smp.size()), 32'd48);
    for (int i = 0; i < smp.size(); i++) begin
      checkOutput("b2b_data", 32'(smp[i].d), 32'(i));
      checkOutput("b2b_sob", 32'(smp[i].s), 32'(i % 16 == 0));
      checkOutput("b2b_eob", 32'(smp[i].e), 32'(i % 16 == 15));
    end
    checkOutput("b2b_pblk_n", 32'(pblkCycs.size()), 32'd3);
    for (int i = 0; i < pblkVals.size(); i++)
      checkOutput("b2b_pblk_val", 32'(pblkVals[i]), 32'd16);
    for (int i = 1; i < pblkCycs.size(); i++)
      checkOutput("b2b_period", 32'(pblkCycs[i] - pblkCycs[i-1]), 32'd18);
    if (startCycs.size() > 1 && pblkCycs.size() > 0)
      checkOutput("b2b_restart_gap", 32'(startCycs[1] - pblkCycs[0]), 32'd2);

    // Synchronous reset mid-block abandons it without release
    clearMon();
    fillBlocks(1);
    applyStimulus(1'b1, 1'b0, 16);
    waitSamples(7, 100);
    checkOutput("mid_count", 32'(smp.size()), 32'd7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkReset("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    clearMon();
    rst_n = 1'b1;
    waitSamples(16, 100);
    waitIdle(50);
    checkBlock("restart", 1'b0);
    checkOutput("restart_pblk_n", 32'(pblkCycs.size()), 32'd1);
    checkOutput("restart_stock", 32'(c_st), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
